resonator_peak_detector: RTL

- Downstream stage of digital_resonator; consumes resonator output q (connected to d here) on the same sample-rate enable strobe.
- Tracks peak absolute amplitude over fixed windows of WINDOW_LEN samples and publishes one peak per window.
- Drives a debounced, hysteretic tone-detect flag.
- Runs at 50 MHz system clock; enable is one cycle wide at the 5 kHz sample rate.

---
 rtl/resonator_peak_detector.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/resonator_peak_detector.sv
// rtl/resonator_peak_detector.sv - windowed peak |d| tracker with debounced hysteretic tone detect
// Optional feature macro: RESONATOR_PEAK_MEAN_ABS_EN (per-window mean |d| on mean_abs).
module resonator_peak_detector #(
  parameter int          DATA_WIDTH = 16,
  parameter int          WINDOW_LEN = 256,
  parameter logic [15:0] THRESH_ON  = 16'd8192,
  parameter logic [15:0] THRESH_OFF = 16'd4096,
  parameter int          DEBOUNCE   = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic signed [DATA_WIDTH-1:0]  d,
  output logic [DATA_WIDTH-1:0]         peak,
  output logic                          peak_valid,
  output logic                          tone_detected,
  output logic [DATA_WIDTH-1:0]         mean_abs,
  output logic [$clog2(WINDOW_LEN)-1:0] sample_idx
);
  localparam int                    IDX_W    = $clog2(WINDOW_LEN);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(WINDOW_LEN - 1);
  localparam logic [DATA_WIDTH-1:0] TH_ON    = DATA_WIDTH'(THRESH_ON);
  localparam logic [DATA_WIDTH-1:0] TH_OFF   = DATA_WIDTH'(THRESH_OFF);
  localparam logic [3:0]            DEB      = 4'(DEBOUNCE);

  typedef enum logic [1:0] {S_IDLE, S_ARMING, S_DETECTED, S_RELEASING} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d, cnt_inc;
  logic [DATA_WIDTH-1:0]  peak_q, peak_d, running_max_q, running_max_d;
  logic [DATA_WIDTH-1:0]  abs_d, cand_max;
  logic [IDX_W-1:0]       sample_idx_q, sample_idx_d;
  logic                   peak_valid_q, peak_valid_d, tone_q, tone_d;
  logic                   win_close, peak_on, peak_off;

  // Two's-complement negate; the most negative sample lands on 2^(W-1) unsigned.
  always_comb begin
    abs_d     = d[DATA_WIDTH-1] ? (~$unsigned(d) + DATA_WIDTH'(1)) : $unsigned(d);
    cand_max  = (abs_d > running_max_q) ? abs_d : running_max_q;
    win_close = enable && (sample_idx_q == LAST_IDX);
  end

  always_comb begin
    peak_d        = peak_q;
    peak_valid_d  = 1'b0;
    running_max_d = running_max_q;
    sample_idx_d  = sample_idx_q;
    if (enable) begin
      if (win_close) begin
        peak_d        = cand_max;
        peak_valid_d  = 1'b1;
        running_max_d = '0;
        sample_idx_d  = '0;
      end else begin
        running_max_d = cand_max;
        sample_idx_d  = sample_idx_q + IDX_W'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cnt_inc  = cnt_q + 4'd1;
    peak_on  = (peak_q >= TH_ON);
    peak_off = (peak_q < TH_OFF);
    if (peak_valid_q) begin
      case (state_q)
        S_IDLE: if (peak_on) begin
          if (DEB == 4'd1) begin state_d = S_DETECTED; cnt_d = '0; end
          else begin state_d = S_ARMING; cnt_d = 4'd1; end
        end
        S_ARMING: if (!peak_on) begin state_d = S_IDLE; cnt_d = '0; end
          else if (cnt_inc == DEB) begin state_d = S_DETECTED; cnt_d = '0; end
          else cnt_d = cnt_inc;
        S_DETECTED: if (peak_off) begin
          if (DEB == 4'd1) begin state_d = S_IDLE; cnt_d = '0; end
          else begin state_d = S_RELEASING; cnt_d = 4'd1; end
        end
        S_RELEASING: if (!peak_off) begin state_d = S_DETECTED; cnt_d = '0; end
          else if (cnt_inc == DEB) begin state_d = S_IDLE; cnt_d = '0; end
          else cnt_d = cnt_inc;
        default: begin state_d = S_IDLE; cnt_d = '0; end
      endcase
    end
    tone_d = (state_d == S_DETECTED) || (state_d == S_RELEASING);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      peak_q        <= '0;
      peak_valid_q  <= 1'b0;
      running_max_q <= '0;
      sample_idx_q  <= '0;
      tone_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      peak_q        <= peak_d;
      peak_valid_q  <= peak_valid_d;
      running_max_q <= running_max_d;
      sample_idx_q  <= sample_idx_d;
      tone_q        <= tone_d;
    end
  end

`ifdef RESONATOR_PEAK_MEAN_ABS_EN
  localparam int SUM_W = DATA_WIDTH + IDX_W;
  logic [SUM_W-1:0]      sum_q, sum_d, sum_next;
  logic [DATA_WIDTH-1:0] mean_q, mean_d;

  always_comb begin
    sum_next = sum_q + SUM_W'(abs_d);
    sum_d    = sum_q;
    mean_d   = mean_q;
    if (enable) begin
      if (win_close) begin
        mean_d = DATA_WIDTH'(sum_next >> IDX_W);
        sum_d  = '0;
      end else begin
        sum_d  = sum_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q  <= '0;
      mean_q <= '0;
    end else begin
      sum_q  <= sum_d;
      mean_q <= mean_d;
    end
  end

  assign mean_abs = mean_q;
`else
  assign mean_abs = '0;
`endif

  assign peak          = peak_q;
  assign peak_valid    = peak_valid_q;
  assign tone_detected = tone_q;
  assign sample_idx    = sample_idx_q;
endmodule
